// File: rtl/mandelbrot_example_axi_pkg.sv
// mandelbrot_example_axi_pkg: shared AXI helpers for the example read/write masters
package mandelbrot_example_axi_pkg;
  localparam int TX_CNT_W = 24;
  typedef logic [TX_CNT_W-1:0] tx_cnt_t;
  function automatic logic [2:0] axsize_f(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction
  function automatic longint burst_bytes_f(input int data_width, input int burst_len);
    return longint'(burst_len) * longint'(data_width / 8);
  endfunction
endpackage

// File: rtl/mandelbrot_example_axi_read_master_if.sv
// mandelbrot_example_axi_read_master_if: AXI4 AR/R channels plus the AXI4-Stream output
interface mandelbrot_example_axi_read_master_if #(
  parameter int C_ADDR_WIDTH = 64,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ID_WIDTH   = 1
);
  logic                    arvalid, arready;
  logic [C_ADDR_WIDTH-1:0] araddr;
  logic [C_ID_WIDTH-1:0]   arid;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic                    rvalid, rready, rlast;
  logic [C_DATA_WIDTH-1:0] rdata;
  logic [C_ID_WIDTH-1:0]   rid;
  logic                    m_tvalid, m_tready, m_tlast;
  logic [C_DATA_WIDTH-1:0] m_tdata;
  modport master (
    output arvalid, araddr, arid, arlen, arsize, rready, m_tvalid, m_tdata, m_tlast,
    input  arready, rvalid, rdata, rlast, rid, m_tready
  );
  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, rready, m_tvalid, m_tdata, m_tlast,
    output arready, rvalid, rdata, rlast, rid, m_tready
  );
endinterface

// File: rtl/mandelbrot_example_counter.sv
// mandelbrot_example_counter: loadable up/down counter with zero flag
module mandelbrot_example_counter #(
  parameter int WIDTH = 8
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             load,
  input  logic             incr,
  input  logic             decr,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             is_zero
);
  always_ff @(posedge aclk)
    if (areset) count <= '0;
    else if (load) count <= load_value;
    else if (incr & ~decr) count <= count + 1'b1;
    else if (decr & ~incr) count <= count - 1'b1;
  assign is_zero = count == '0;
endmodule

// File: rtl/mandelbrot_example_axi_read_master.sv
// mandelbrot_example_axi_read_master: AXI4 read-burst master forwarding R beats unbuffered to a stream
module mandelbrot_example_axi_read_master
  import mandelbrot_example_axi_pkg::*;
#(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 32,
  parameter int C_ID_WIDTH        = 1,
  parameter int C_LENGTH_WIDTH    = 32,
  parameter int C_BURST_LEN       = 256,
  parameter int C_LOG_BURST_LEN   = 8,
  parameter int C_MAX_OUTSTANDING = 4
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]   ctrl_offset,
  input  logic [C_LENGTH_WIDTH-1:0] ctrl_length,
  output logic                      ctrl_done,
  mandelbrot_example_axi_read_master_if.master axi
);
  localparam int TX_W = C_LENGTH_WIDTH - C_LOG_BURST_LEN;
  localparam logic [C_ADDR_WIDTH-1:0] BURST_BYTES = C_ADDR_WIDTH'(burst_bytes_f(C_DATA_WIDTH, C_BURST_LEN));
  localparam logic [7:0] FULL_LEN = 8'(C_BURST_LEN - 1);
  localparam logic [7:0] MAX_OUT = 8'(C_MAX_OUTSTANDING);
  logic busy, start_d, zero_len, zero_done, ar_pending, arvalid_r;
  logic start_ok, ar_hs, r_last_hs, ar_zero, r_zero, out_zero_unused, unused;
  logic [C_ADDR_WIDTH-1:0] araddr_r;
  logic [C_LENGTH_WIDTH-1:0] len_m1;
  logic [TX_W-1:0] num_tx, ar_cnt, r_cnt;
  logic [7:0] final_len, out_cnt;
  assign start_ok  = ctrl_start & ~busy;
  assign len_m1    = ctrl_length - 1'b1;
  assign ar_hs     = axi.arvalid & axi.arready;
  assign r_last_hs = axi.rvalid & axi.m_tready & axi.rlast;
  // A zero-length request completes from the start pipeline alone, two cycles after start
  assign ctrl_done = busy & ((r_last_hs & r_zero & ~zero_len) | zero_done);
  always_ff @(posedge aclk)
    if (areset) begin
      busy       <= 1'b0;
      start_d    <= 1'b0;
      zero_len   <= 1'b0;
      zero_done  <= 1'b0;
      ar_pending <= 1'b0;
      arvalid_r  <= 1'b0;
      araddr_r   <= '0;
      num_tx     <= '0;
      final_len  <= '0;
    end else begin
      start_d   <= start_ok;
      zero_done <= start_d & zero_len;
      if (start_ok) begin
        busy       <= 1'b1;
        zero_len   <= ctrl_length == '0;
        ar_pending <= ctrl_length != '0;
        num_tx     <= len_m1[C_LENGTH_WIDTH-1:C_LOG_BURST_LEN];
        final_len  <= 8'(len_m1[C_LOG_BURST_LEN-1:0]);
        araddr_r   <= ctrl_offset;
      end else if (ctrl_done) busy <= 1'b0;
      if (ar_hs) begin
        araddr_r <= araddr_r + BURST_BYTES;
        if (ar_zero) ar_pending <= 1'b0;
      end
      arvalid_r <= axi.arvalid ? ~axi.arready : ar_pending & (out_cnt < MAX_OUT);
    end
  mandelbrot_example_counter #(.WIDTH(TX_W)) u_ar_cnt (
    .aclk(aclk), .areset(areset), .load(start_d), .incr(1'b0), .decr(ar_hs),
    .load_value(num_tx), .count(ar_cnt), .is_zero(ar_zero)
  );
  mandelbrot_example_counter #(.WIDTH(TX_W)) u_r_cnt (
    .aclk(aclk), .areset(areset), .load(start_d), .incr(1'b0), .decr(r_last_hs),
    .load_value(num_tx), .count(r_cnt), .is_zero(r_zero)
  );
  mandelbrot_example_counter #(.WIDTH(8)) u_out_cnt (
    .aclk(aclk), .areset(areset), .load(1'b0), .incr(ar_hs), .decr(r_last_hs),
    .load_value(8'd0), .count(out_cnt), .is_zero(out_zero_unused)
  );
  assign axi.arvalid  = arvalid_r;
  assign axi.araddr   = araddr_r;
  assign axi.arid     = '0;
  assign axi.arlen    = ar_zero ? final_len : FULL_LEN;
  assign axi.arsize   = axsize_f(C_DATA_WIDTH);
  assign axi.rready   = axi.m_tready;
  assign axi.m_tvalid = axi.rvalid;
  assign axi.m_tdata  = axi.rdata;
  assign axi.m_tlast  = axi.rlast & r_zero;
  assign unused = ^{axi.rid, out_zero_unused, r_cnt};
endmodule
